// File: rtl/mem_access_unit.sv
// Load/store front-end for a 32-bit byte-addressable block RAM with a one-deep response register.
// Define MEM_ACCESS_STATS_EN to add per-class counters of accepted requests.
module mem_access_unit #(
  parameter int DEPTH = 512
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [31:0]                   i_req_addr,
  input  logic                          i_req_we,
  input  logic [1:0]                    i_req_size,
  input  logic                          i_req_unsigned,
  input  logic [31:0]                   i_req_wdata,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [31:0]                   o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic [$clog2(DEPTH)-1:0]      o_mem_addr,
  output logic [31:0]                   o_mem_wdata,
  output logic                          o_mem_we,
  output logic [2:0]                    o_mem_subaddr,
  input  logic [31:0]                   i_mem_rdata
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0]                   o_stat_loads,
  output logic [31:0]                   o_stat_stores,
  output logic [31:0]                   o_stat_errs
`endif
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  logic                  pending_q, pending_d;
  logic                  is_load_q, is_load_d;
  logic                  err_q, err_d;
  logic [1:0]            offset_q, offset_d;
  size_e                 size_q, size_d;
  logic                  unsigned_q, unsigned_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  size_e                 req_size;
  logic                  accept;
  logic                  req_err;
  logic [31:0]           shifted;

  assign req_size    = size_e'(i_req_size);
  assign o_req_ready = !i_rst && (!pending_q || i_rsp_ready);
  assign accept      = i_req_valid && o_req_ready;

  always_comb begin
    req_err = 1'b0;
    unique case (req_size)
      SZ_HALF: req_err = i_req_addr[0];
      SZ_WORD: req_err = |i_req_addr[1:0];
      SZ_ILL:  req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (|i_req_addr[31:ADDR_WIDTH+2]) req_err = 1'b1;
  end

  // RAM side: the address follows the request only in the accept cycle so a stalled
  // response keeps the RAM output (and thus o_rsp_rdata) stable.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    o_mem_addr    = addr_q;
    o_mem_we      = 1'b0;
    o_mem_subaddr = 3'd0;
    o_mem_wdata   = i_req_wdata;
    if (accept) begin
      o_mem_addr = i_req_addr[ADDR_WIDTH+1:2];
      o_mem_we   = i_req_we && !req_err;
      unique case (req_size)
        SZ_BYTE: begin
          o_mem_subaddr = {1'b1, i_req_addr[1:0]};
          o_mem_wdata   = {4{i_req_wdata[7:0]}};
        end
        SZ_HALF: begin
          o_mem_subaddr = {2'b01, i_req_addr[1]};
          o_mem_wdata   = {2{i_req_wdata[15:0]}};
        end
        SZ_WORD: o_mem_subaddr = 3'd1;
        default: o_mem_subaddr = 3'd0;
      endcase
    end
  end

  always_comb begin
    pending_d  = pending_q;
    is_load_d  = is_load_q;
    err_d      = err_q;
    offset_d   = offset_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    if (accept) begin
      pending_d  = 1'b1;
      is_load_d  = !i_req_we;
      err_d      = req_err;
      offset_d   = i_req_addr[1:0];
      size_d     = req_size;
      unsigned_d = i_req_unsigned;
      addr_d     = i_req_addr[ADDR_WIDTH+1:2];
    end else if (pending_q && i_rsp_ready) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_rst) begin
      pending_q  <= 1'b0;
      is_load_q  <= 1'b0;
      err_q      <= 1'b0;
      offset_q   <= 2'd0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      pending_q  <= pending_d;
      is_load_q  <= is_load_d;
      err_q      <= err_d;
      offset_q   <= offset_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
    end
  end

  // Load data: shift the addressed lane down, then truncate and extend.
  assign shifted = i_mem_rdata >> {offset_q, 3'b000};

  assign o_rsp_valid = pending_q;
  assign o_rsp_err   = pending_q && err_q;

  always_comb begin
    o_rsp_rdata = 32'd0;
    if (pending_q && is_load_q && !err_q) begin
      unique case (size_q)
        SZ_BYTE: o_rsp_rdata = {{24{shifted[7] & ~unsigned_q}}, shifted[7:0]};
        SZ_HALF: o_rsp_rdata = {{16{shifted[15] & ~unsigned_q}}, shifted[15:0]};
        default: o_rsp_rdata = shifted;
      endcase
    end
  end

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] loads_q, loads_d;
  logic [31:0] stores_q, stores_d;
  logic [31:0] errs_q, errs_d;

  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    errs_d   = errs_q;
    if (accept) begin
      if (req_err)       errs_d   = errs_q + 32'd1;
      else if (i_req_we) stores_d = stores_q + 32'd1;
      else               loads_d  = loads_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      loads_q  <= 32'd0;
      stores_q <= 32'd0;
      errs_q   <= 32'd0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      errs_q   <= errs_d;
    end
  end

  assign o_stat_loads  = loads_q;
  assign o_stat_stores = stores_q;
  assign o_stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table with a response scoreboard,
// plus hand-written stall and reset sequences against a small RAM model.
module tb_mem_access_unit;

  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [31:0]   req_addr, req_wdata;
  logic [1:0]    req_size;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_we;
  logic [2:0]    mem_subaddr;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0]   stat_loads, stat_stores, stat_errs;
`endif

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_addr     (req_addr),
    .i_req_we       (req_we),
    .i_req_size     (req_size),
    .i_req_unsigned (req_unsigned),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_we       (mem_we),
    .o_mem_subaddr  (mem_subaddr),
    .i_mem_rdata    (mem_rdata)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .o_stat_loads   (stat_loads),
    .o_stat_stores  (stat_stores),
    .o_stat_errs    (stat_errs)
`endif
  );

  // RAM model: sub-address lane writes, registered read-first output.
  logic [31:0] ram [DEPTH];
  int          cyc = 0;
  int          we_count = 0;

  initial for (int i = 0; i < DEPTH; i++) ram[i] = 32'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      we_count <= we_count + 1;
      case (mem_subaddr)
        3'd1: ram[mem_addr]        <= mem_wdata;
        3'd2: ram[mem_addr][15:0]  <= mem_wdata[15:0];
        3'd3: ram[mem_addr][31:16] <= mem_wdata[31:16];
        3'd4: ram[mem_addr][7:0]   <= mem_wdata[7:0];
        3'd5: ram[mem_addr][15:8]  <= mem_wdata[15:8];
        3'd6: ram[mem_addr][23:16] <= mem_wdata[23:16];
        3'd7: ram[mem_addr][31:24] <= mem_wdata[31:24];
        default: ;
      endcase
    end
    mem_rdata <= ram[mem_addr];
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [AW-1:0] maddr;
    logic          mwe;
    logic [2:0]    sub;
    logic [31:0]   mwdata;
    logic [31:0]   rdata;
    logic          err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t sb[$];

  // Response monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        if (e.due >= 0) check("rsp_latency", cyc, e.due);
      end
    end
  end

  task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic issue(input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v.we, v.size, v.uns, v.addr, v.wdata);
    #1;
    check("req_ready_b2b", {31'd0, req_ready}, 32'd1);
    check("mem_addr", {23'd0, mem_addr}, {23'd0, v.maddr});
    check("mem_we", {31'd0, mem_we}, {31'd0, v.mwe});
    if (v.mwe) begin
      check("mem_subaddr", {29'd0, mem_subaddr}, {29'd0, v.sub});
      check("mem_wdata", mem_wdata, v.mwdata);
    end
    e.rdata = v.rdata;
    e.err   = v.err;
    e.due   = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("we_pulse_end", {31'd0, mem_we}, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #3;
    check("drain_empty", sb.size(), 32'd0);
  endtask

  vec_t vecs[20];

  initial begin
    exp_t        e;
    logic [31:0] held;

    //            we  sz   uns  addr          wdata         maddr   mwe sub   mwdata        rdata         err
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 9'h004, 1'b1, 3'd1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         9'h004, 1'b0, 3'd0, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h1234_56A5, 9'h004, 1'b1, 3'd7, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0,         9'h004, 1'b0, 3'd0, 32'h0,         32'hFFFF_FFA5, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0,         9'h004, 1'b0, 3'd0, 32'h0,         32'h0000_00A5, 1'b0};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0011, 32'h0,         9'h004, 1'b0, 3'd0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0800, 32'h1111_1111, 9'h000, 1'b0, 3'd0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'hCAFE_8001, 9'h008, 1'b1, 3'd3, 32'h8001_8001, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0,         9'h008, 1'b0, 3'd0, 32'h0,         32'hFFFF_8001, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0020, 32'h0,         9'h008, 1'b0, 3'd0, 32'h0,         32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,         9'h000, 1'b0, 3'd0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 2'd0, 1'b0, 32'h0000_0021, 32'h0000_007F, 9'h008, 1'b1, 3'd5, 32'h7F7F_7F7F, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,         9'h008, 1'b0, 3'd0, 32'h0,         32'h8001_7F00, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h0000_0021, 32'h0,         9'h008, 1'b0, 3'd0, 32'h0,         32'h0000_007F, 1'b0};
    vecs[14] = '{1'b1, 2'd2, 1'b0, 32'h0000_07FC, 32'h0123_4567, 9'h1FF, 1'b1, 3'd1, 32'h0123_4567, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h0000_07FC, 32'h0,         9'h1FF, 1'b0, 3'd0, 32'h0,         32'h0123_4567, 1'b0};
    vecs[16] = '{1'b0, 2'd2, 1'b0, 32'h0000_07FE, 32'h0,         9'h1FF, 1'b0, 3'd0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[17] = '{1'b0, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0,         9'h1FF, 1'b0, 3'd0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[18] = '{1'b0, 2'd1, 1'b1, 32'h0000_07FE, 32'h0,         9'h1FF, 1'b0, 3'd0, 32'h0,         32'h0000_0123, 1'b0};
    vecs[19] = '{1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'h0,         9'h004, 1'b0, 3'd0, 32'h0,         32'hFFFF_FFEF, 1'b0};

    rst = 1'b1;
    rsp_ready = 1'b1;
    drive(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);
    check("idle_mem_addr", {23'd0, mem_addr}, 32'd0);
    check("idle_we_count", we_count, 32'd0);

    // Vector table, issued back to back with the response side always ready.
    for (int i = 0; i < 20; i++) issue(vecs[i]);
    idle();
    drain();
    check("table_we_count", we_count, 32'd5);
`ifdef MEM_ACCESS_STATS_EN
    check("stat_loads", stat_loads, 32'd10);
    check("stat_stores", stat_stores, 32'd5);
    check("stat_errs", stat_errs, 32'd5);
`endif

    // Stalled response: held for three cycles with a competing request waiting.
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    check("stall_accept", {31'd0, req_ready}, 32'd1);
    e.rdata = 32'hA5AD_BEEF; e.err = 1'b0; e.due = -1;
    sb.push_back(e);
    @(negedge clk);
    drive(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0);
    #1;
    held = rsp_rdata;
    check("stall_first_rdata", held, 32'hA5AD_BEEF);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      check("stall_mem_addr", {23'd0, mem_addr}, 32'd4);
      check("stall_rdata", rsp_rdata, held);
      check("stall_mem_we", {31'd0, mem_we}, 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("release_req_ready", {31'd0, req_ready}, 32'd1);
    check("release_mem_addr", {23'd0, mem_addr}, 32'd8);
    e.rdata = 32'h8001_7F00; e.err = 1'b0; e.due = cyc + 1;
    sb.push_back(e);
    idle();
    drain();

    // Reset with a pending response: discarded, no write while reset is high.
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, 2'd2, 1'b0, 32'h0000_07FC, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h0000_0000);
    #1;
    check("rstmid_rsp_valid_before", {31'd0, rsp_valid}, 32'd1);
    check("rstmid_req_ready", {31'd0, req_ready}, 32'd0);
    check("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("rstmid_rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
    check("rstmid_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rstmid_mem_addr", {23'd0, mem_addr}, 32'd0);
    check("rstmid_we_count", we_count, 32'd5);
    check("rstmid_ram_intact", ram[4], 32'hA5AD_BEEF);
`ifdef MEM_ACCESS_STATS_EN
    check("rst_stat_loads", stat_loads, 32'd0);
    check("rst_stat_stores", stat_stores, 32'd0);
    check("rst_stat_errs", stat_errs, 32'd0);
`endif
    repeat (2) @(negedge clk);
    #3;
    check("rstmid_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
